// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one byte transmitter among
// NUM_REQ byte-stream requesters. A grant stays with its requester until the
// packet ends, the requester drops valid, or MAX_BURST bytes have been sent.
//
// Optional build macro: UART_ARB_PRIORITY_EN makes requester 0 strict high
// priority without disturbing the round-robin order of the others.
//
// Ports:
//   clk, nReset   - clock, asynchronous active-low reset
//   req_valid     - per-requester byte available
//   req_data      - requester i byte in bits [8i+7:8i]
//   req_last      - per-requester end-of-packet flag for the current byte
//   req_ready     - one-cycle accept pulse to the granted requester
//   tx_data       - byte presented to the transmitter (registered)
//   tx_valid      - one-cycle start pulse to the transmitter
//   tx_done       - transmitter finished the current byte
//   grant_id      - current or most recent grantee
//   grant_active  - a grant is held
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                       clk,
  input  logic                       nReset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_done,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       grant_active
);

  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam int unsigned CW  = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     grant_id_q, grant_id_d;
  logic [IDW-1:0]     last_grant_q, last_grant_d;
  logic [CW-1:0]      count_q, count_d;
  logic               last_flag_q, last_flag_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic               grant_active_q;

  logic [IDW-1:0]     rr_sel;
  logic [IDW-1:0]     rel_ptr;
  logic               burst_hit;
  logic [7:0]         req_bytes [NUM_REQ];

  // Unpack the flat data bus into one byte per requester
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_bytes[g] = req_data[8*g +: 8];
  end

  // First valid requester after last_grant, wrapping modulo NUM_REQ
  always_comb begin
    logic           found;
    logic [IDW-1:0] cand;
    rr_sel = last_grant_q;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IDW'((32'(last_grant_q) + i) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        rr_sel = cand;
        found  = 1'b1;
      end
    end
  end

  // Rotation pointer on release; a priority grant to 0 leaves it untouched
`ifdef UART_ARB_PRIORITY_EN
  assign rel_ptr = (grant_id_q == '0) ? last_grant_q : grant_id_q;
`else
  assign rel_ptr = grant_id_q;
`endif

  // The byte completing now would be the MAX_BURST-th of this grant
  assign burst_hit = (MAX_BURST != 0) && ((32'(count_q) + 32'd1) == MAX_BURST);

  // Next-state and output decode
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    count_d      = count_q;
    last_flag_d  = last_flag_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = 1'b0;
    req_ready_d  = '0;

    case (state_q)
      IDLE: begin
        count_d = '0;
        if (|req_valid) begin
          grant_id_d = rr_sel;
`ifdef UART_ARB_PRIORITY_EN
          if (req_valid[0]) grant_id_d = '0;
`endif
          state_d = LOAD;
        end
      end

      LOAD: begin
        if (req_valid[grant_id_q]) begin
          tx_data_d               = req_bytes[grant_id_q];
          last_flag_d             = req_last[grant_id_q];
          req_ready_d[grant_id_q] = 1'b1;
          tx_valid_d              = 1'b1;
          state_d                 = WAIT;
        end else begin
          last_grant_d = rel_ptr;
          count_d      = '0;
          state_d      = IDLE;
        end
      end

      WAIT: begin
        if (tx_done) begin
          if (last_flag_q || burst_hit || !req_valid[grant_id_q]) begin
            last_grant_d = rel_ptr;
            count_d      = '0;
            state_d      = IDLE;
          end else begin
            count_d = (&count_q) ? count_q : count_q + CW'(1);
            state_d = LOAD;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q        <= IDLE;
      grant_id_q     <= '0;
      last_grant_q   <= IDW'(NUM_REQ - 1);
      count_q        <= '0;
      last_flag_q    <= 1'b0;
      tx_data_q      <= '0;
      tx_valid_q     <= 1'b0;
      req_ready_q    <= '0;
      grant_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_id_q     <= grant_id_d;
      last_grant_q   <= last_grant_d;
      count_q        <= count_d;
      last_flag_q    <= last_flag_d;
      tx_data_q      <= tx_data_d;
      tx_valid_q     <= tx_valid_d;
      req_ready_q    <= req_ready_d;
      grant_active_q <= (state_d != IDLE);
    end
  end

  assign req_ready    = req_ready_q;
  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;
  assign grant_id     = grant_id_q;
  assign grant_active = grant_active_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter. Instance 0 uses MAX_BURST=8, instance 1
// uses MAX_BURST=0. Each instance has queue-based requester models and a
// transmitter model returning tx_done 10 cycles after each tx_valid.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int unsigned NR = 4;

  logic clk = 1'b0;
  logic nReset;
  always #5 clk = ~clk;

  logic [1:0][NR-1:0]   rv, rl;
  logic [1:0][8*NR-1:0] rd;
  logic [1:0]           txdone;
  wire  [1:0][NR-1:0]   rr;
  wire  [1:0][7:0]      txd;
  wire  [1:0]           txv, gact;
  wire  [1:0][1:0]      gid;

  uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(8)) dut (
    .clk(clk), .nReset(nReset), .req_valid(rv[0]), .req_data(rd[0]),
    .req_last(rl[0]), .req_ready(rr[0]), .tx_data(txd[0]), .tx_valid(txv[0]),
    .tx_done(txdone[0]), .grant_id(gid[0]), .grant_active(gact[0]));

  uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(0)) dut_nolimit (
    .clk(clk), .nReset(nReset), .req_valid(rv[1]), .req_data(rd[1]),
    .req_last(rl[1]), .req_ready(rr[1]), .tx_data(txd[1]), .tx_valid(txv[1]),
    .tx_done(txdone[1]), .grant_id(gid[1]), .grant_active(gact[1]));

  logic [8:0] mem [2][NR][64];
  int head [2][NR];
  int tail [2][NR];
  int tcnt [2];
  int log_id  [2][128];
  int log_dat [2][128];
  int nlog [2];
  int rcnt [2][NR];
  int vectors;
  int errors;

  // Requester outputs follow the queue heads; tx_done is the last count
  always_comb begin
    rv = '0;
    rl = '0;
    rd = '0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NR; i++) begin
        if (head[k][i] != tail[k][i]) begin
          rv[k][i]        = 1'b1;
          rd[k][8*i +: 8] = mem[k][i][head[k][i] % 64][7:0];
          rl[k][i]        = mem[k][i][head[k][i] % 64][8];
        end
      end
    end
    for (int k = 0; k < 2; k++) txdone[k] = (tcnt[k] == 1);
  end

  // Requester pops on accept; transmitter busy counter
  always @(posedge clk or negedge nReset) begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NR; i++)
        if (nReset && rr[k][i] && rv[k][i]) head[k][i] <= head[k][i] + 1;
      if (!nReset)          tcnt[k] <= 0;
      else if (txv[k])      tcnt[k] <= 10;
      else if (tcnt[k] != 0) tcnt[k] <= tcnt[k] - 1;
    end
  end

  // Log every transmitted byte and check accept pulses against valid
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (txv[k]) begin
        log_id[k][nlog[k] % 128]  = int'(gid[k]);
        log_dat[k][nlog[k] % 128] = int'(txd[k]);
        nlog[k] = nlog[k] + 1;
      end
      if (rr[k] != '0) begin
        vectors++;
        if (((rr[k] & ~rv[k]) != '0) || ($countones(rr[k]) > 1)) begin
          errors++;
          $display("FAIL ready_vs_valid inst%0d: ready=%b valid=%b, required one-hot ready within valid",
                   k, rr[k], rv[k]);
        end
        for (int i = 0; i < NR; i++) if (rr[k][i]) rcnt[k][i] = rcnt[k][i] + 1;
      end
    end
  end

  task automatic push(input int k, input int i, input logic [7:0] d, input logic last);
    mem[k][i][tail[k][i] % 64] = {last, d};
    tail[k][i] = tail[k][i] + 1;
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NR; i++) tail[k][i] = head[k][i];
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idle(input int k, input int budget, input string name);
    int  n;
    bit  busy;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      busy = gact[k] || (tcnt[k] != 0);
      for (int i = 0; i < NR; i++) if (head[k][i] != tail[k][i]) busy = 1'b1;
    end while (busy && n < budget);
    vectors++;
    if (busy) begin
      errors++;
      $display("FAIL %s timeout: still busy after %0d cycles, required idle", name, budget);
    end
  endtask

  task automatic test_reset();
    nReset = 1'b1;
    #1 nReset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      vectors++; if (rr[k] !== '0)    begin errors++; $display("FAIL reset_ready inst%0d: got %b, required 0", k, rr[k]); end
      vectors++; if (txd[k] !== 8'h00) begin errors++; $display("FAIL reset_tx_data inst%0d: got %h, required 00", k, txd[k]); end
      vectors++; if (txv[k] !== 1'b0)  begin errors++; $display("FAIL reset_tx_valid inst%0d: got %b, required 0", k, txv[k]); end
      vectors++; if (gid[k] !== 2'd0)  begin errors++; $display("FAIL reset_grant_id inst%0d: got %0d, required 0", k, gid[k]); end
      vectors++; if (gact[k] !== 1'b0) begin errors++; $display("FAIL reset_grant_active inst%0d: got %b, required 0", k, gact[k]); end
    end
  endtask

  task automatic test_single();
    int base, r0, ndone, n;
    do_reset();
    push(0, 2, 8'h41, 1'b0);
    push(0, 2, 8'h42, 1'b1);
    base = nlog[0];
    r0 = rcnt[0][2];
    nReset = 1'b1;
    ndone = 0;
    n = 0;
    while (ndone < 2 && n < 200) begin
      @(negedge clk);
      n++;
      if (txdone[0]) ndone++;
    end
    vectors++;
    if (ndone != 2) begin errors++; $display("FAIL single_done_count: got %0d, required 2", ndone); end
    vectors++;
    if (gact[0] !== 1'b1) begin errors++; $display("FAIL single_active_at_done: got %b, required 1", gact[0]); end
    @(negedge clk);
    vectors++;
    if (gact[0] !== 1'b0) begin errors++; $display("FAIL single_active_after_done: got %b, required 0", gact[0]); end
    vectors++;
    if (gid[0] !== 2'd2) begin errors++; $display("FAIL single_grant_id: got %0d, required 2", gid[0]); end
    wait_idle(0, 200, "single");
    vectors++;
    if (nlog[0] - base != 2) begin errors++; $display("FAIL single_tx_count: got %0d, required 2", nlog[0] - base); end
    vectors++;
    if (log_id[0][base % 128] !== 2 || log_dat[0][base % 128] !== 'h41) begin
      errors++; $display("FAIL single_byte0: got id=%0d data=%02h, required id=2 data=41",
                         log_id[0][base % 128], log_dat[0][base % 128]);
    end
    vectors++;
    if (log_id[0][(base + 1) % 128] !== 2 || log_dat[0][(base + 1) % 128] !== 'h42) begin
      errors++; $display("FAIL single_byte1: got id=%0d data=%02h, required id=2 data=42",
                         log_id[0][(base + 1) % 128], log_dat[0][(base + 1) % 128]);
    end
    vectors++;
    if (rcnt[0][2] - r0 != 2) begin errors++; $display("FAIL single_ready_count: got %0d, required 2", rcnt[0][2] - r0); end
  endtask

  task automatic test_round_robin();
    int base;
    int exp_id [6];
    exp_id = '{0, 1, 2, 3, 0, 1};
    do_reset();
    push(0, 0, 8'h10, 1'b1); push(0, 0, 8'h14, 1'b1);
    push(0, 1, 8'h11, 1'b1); push(0, 1, 8'h15, 1'b1);
    push(0, 2, 8'h12, 1'b1);
    push(0, 3, 8'h13, 1'b1);
    base = nlog[0];
    nReset = 1'b1;
    wait_idle(0, 500, "round_robin");
    vectors++;
    if (nlog[0] - base != 6) begin errors++; $display("FAIL rr_tx_count: got %0d, required 6", nlog[0] - base); end
    for (int j = 0; j < 6; j++) begin
      vectors++;
      if (log_id[0][(base + j) % 128] !== exp_id[j] || log_dat[0][(base + j) % 128] !== 'h10 + j) begin
        errors++; $display("FAIL rr_order[%0d]: got id=%0d data=%02h, required id=%0d data=%02h", j,
                           log_id[0][(base + j) % 128], log_dat[0][(base + j) % 128], exp_id[j], 'h10 + j);
      end
    end
  endtask

  task automatic test_max_burst();
    int base;
    int exp_id [14];
    int exp_dat [14];
    for (int j = 0; j < 8; j++) begin exp_id[j] = 1; exp_dat[j] = 'h80 + j; end
    exp_id[8] = 3; exp_dat[8] = 'hC0;
    exp_id[9] = 3; exp_dat[9] = 'hC1;
    for (int j = 0; j < 4; j++) begin exp_id[10 + j] = 1; exp_dat[10 + j] = 'h88 + j; end
    do_reset();
    for (int j = 0; j < 12; j++) push(0, 1, 8'(8'h80 + j), j == 11);
    push(0, 3, 8'hC0, 1'b0);
    push(0, 3, 8'hC1, 1'b1);
    base = nlog[0];
    nReset = 1'b1;
    wait_idle(0, 1000, "max_burst");
    vectors++;
    if (nlog[0] - base != 14) begin errors++; $display("FAIL burst_tx_count: got %0d, required 14", nlog[0] - base); end
    for (int j = 0; j < 14; j++) begin
      vectors++;
      if (log_id[0][(base + j) % 128] !== exp_id[j] || log_dat[0][(base + j) % 128] !== exp_dat[j]) begin
        errors++; $display("FAIL burst_order[%0d]: got id=%0d data=%02h, required id=%0d data=%02h", j,
                           log_id[0][(base + j) % 128], log_dat[0][(base + j) % 128], exp_id[j], exp_dat[j]);
      end
    end
  endtask

  task automatic test_no_limit();
    int base, eid, edat;
    do_reset();
    for (int j = 0; j < 20; j++) push(1, 0, 8'(j), j == 19);
    push(1, 2, 8'hEE, 1'b1);
    base = nlog[1];
    nReset = 1'b1;
    wait_idle(1, 2000, "no_limit");
    vectors++;
    if (nlog[1] - base != 21) begin errors++; $display("FAIL nolimit_tx_count: got %0d, required 21", nlog[1] - base); end
    for (int j = 0; j < 21; j++) begin
      eid  = (j < 20) ? 0 : 2;
      edat = (j < 20) ? j : 'hEE;
      vectors++;
      if (log_id[1][(base + j) % 128] !== eid || log_dat[1][(base + j) % 128] !== edat) begin
        errors++; $display("FAIL nolimit_order[%0d]: got id=%0d data=%02h, required id=%0d data=%02h", j,
                           log_id[1][(base + j) % 128], log_dat[1][(base + j) % 128], eid, edat);
      end
    end
  endtask

  task automatic test_reset_mid_byte();
    int base, n;
    int exp_id [4];
    int exp_dat [4];
    exp_id  = '{0, 1, 1, 1};
    exp_dat = '{'h55, 'h32, 'h33, 'h34};
    do_reset();
    for (int j = 0; j < 5; j++) push(0, 1, 8'(8'h30 + j), j == 4);
    base = nlog[0];
    nReset = 1'b1;
    n = 0;
    while (nlog[0] - base < 2 && n < 200) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    vectors++;
    if (gact[0] !== 1'b1) begin errors++; $display("FAIL midreset_active_before: got %b, required 1", gact[0]); end
    push(0, 0, 8'h55, 1'b1);
    nReset = 1'b0;
    #1;
    vectors++; if (rr[0] !== '0)    begin errors++; $display("FAIL midreset_ready: got %b, required 0", rr[0]); end
    vectors++; if (txd[0] !== 8'h00) begin errors++; $display("FAIL midreset_tx_data: got %h, required 00", txd[0]); end
    vectors++; if (txv[0] !== 1'b0)  begin errors++; $display("FAIL midreset_tx_valid: got %b, required 0", txv[0]); end
    vectors++; if (gid[0] !== 2'd0)  begin errors++; $display("FAIL midreset_grant_id: got %0d, required 0", gid[0]); end
    vectors++; if (gact[0] !== 1'b0) begin errors++; $display("FAIL midreset_grant_active: got %b, required 0", gact[0]); end
    repeat (2) @(negedge clk);
    base = nlog[0];
    nReset = 1'b1;
    wait_idle(0, 500, "reset_mid_byte");
    vectors++;
    if (nlog[0] - base != 4) begin errors++; $display("FAIL midreset_tx_count: got %0d, required 4", nlog[0] - base); end
    for (int j = 0; j < 4; j++) begin
      vectors++;
      if (log_id[0][(base + j) % 128] !== exp_id[j] || log_dat[0][(base + j) % 128] !== exp_dat[j]) begin
        errors++; $display("FAIL midreset_order[%0d]: got id=%0d data=%02h, required id=%0d data=%02h", j,
                           log_id[0][(base + j) % 128], log_dat[0][(base + j) % 128], exp_id[j], exp_dat[j]);
      end
    end
  endtask

  task automatic test_priority();
    int  base, n;
    bit  seen2;
    int  exp_id [5];
    int  exp_dat [5];
`ifdef UART_ARB_PRIORITY_EN
    exp_id  = '{1, 0, 2, 0, 1};
    exp_dat = '{'hB1, 'hA0, 'hC2, 'hA1, 'hB2};
`else
    exp_id  = '{1, 2, 0, 1, 0};
    exp_dat = '{'hB1, 'hC2, 'hA0, 'hB2, 'hA1};
`endif
    do_reset();
    push(0, 1, 8'hB1, 1'b1);
    base = nlog[0];
    nReset = 1'b1;
    n = 0;
    while (nlog[0] - base < 1 && n < 200) begin @(negedge clk); n++; end
    push(0, 0, 8'hA0, 1'b1);
    push(0, 1, 8'hB2, 1'b1);
    push(0, 2, 8'hC2, 1'b1);
    // Requester 0 comes back only once requester 2 holds the transmitter
    seen2 = 1'b0;
    n = 0;
    while (!seen2 && n < 500) begin
      @(negedge clk);
      n++;
      for (int j = base; j < nlog[0]; j++) if (log_id[0][j % 128] == 2) seen2 = 1'b1;
    end
    vectors++;
    if (!seen2) begin errors++; $display("FAIL prio_grant2_seen: got none, required a grant to 2"); end
    push(0, 0, 8'hA1, 1'b1);
    wait_idle(0, 1000, "priority");
    vectors++;
    if (nlog[0] - base != 5) begin errors++; $display("FAIL prio_tx_count: got %0d, required 5", nlog[0] - base); end
    for (int j = 0; j < 5; j++) begin
      vectors++;
      if (log_id[0][(base + j) % 128] !== exp_id[j] || log_dat[0][(base + j) % 128] !== exp_dat[j]) begin
        errors++; $display("FAIL prio_order[%0d]: got id=%0d data=%02h, required id=%0d data=%02h", j,
                           log_id[0][(base + j) % 128], log_dat[0][(base + j) % 128], exp_id[j], exp_dat[j]);
      end
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_max_burst();
    test_no_limit();
    test_reset_mid_byte();
    test_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
